fir_coeff_loader: RTL and testbench

Upstream coefficient-load stage for the symmetric FIR lowpass filter. It receives a byte stream through a valid/ready handshake, assembles C-bit coefficients MSB-byte first, and drives the filter's coefficient write port (`c_WE`, `c_addr`, `c_in`) once per coefficient for addresses 0 to NCOEF-1. `done` tells downstream logic that a complete coefficient set is resident, so the filter can be held off until that point.

---
 rtl/fir_pkg.sv | 18 +
 rtl/fir_coeff_assembler.sv | 49 ++++
 rtl/fir_coeff_loader.sv | 135 +++++++++++++
 tb/tb_fir_coeff_loader.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Constants shared between the symmetric FIR and its coefficient loader, plus the loader state type.
package fir_pkg;

    localparam int ORD   = 256;
    localparam int C     = 16;
    localparam int NCOEF = (ORD + 1) / 2;
    localparam int AW    = $clog2(NCOEF);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
        CSUM  = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } loader_state_e;

endpackage

// File: rtl/fir_coeff_assembler.sv
// Packs BPC stream bytes (MSB byte first) into one coefficient word.
// word/word_valid are combinational so the loader can capture the word on the same edge as the last byte.
module fir_coeff_assembler #(
    parameter int  BPC = 2,
    localparam int W   = 8 * BPC,
    localparam int CW  = (BPC > 1) ? $clog2(BPC) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         accept,
    input  logic [7:0]   s_data,
    output logic         word_valid,
    output logic [W-1:0] word
);

    logic [CW-1:0] cnt;
    logic          last;

    assign last       = (cnt == CW'(BPC - 1));
    assign word_valid = accept && last;

    generate
        if (BPC > 1) begin : g_multi
            logic [W-9:0] sreg;

            assign word = {sreg, s_data};

            always_ff @(posedge clk) begin
                if (rst || clr) begin
                    sreg <= '0;
                end else if (accept) begin
                    sreg <= word[W-9:0];
                end
            end
        end else begin : g_single
            assign word = s_data;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fir_coeff_loader.sv
// Loads NCOEF coefficients from a byte stream into the FIR write port; all outputs registered.
// Define FIR_COEFF_LOADER_CSUM_EN to require a trailing XOR checksum byte after the last coefficient.
//
// state | meaning
// IDLE  | waiting for start, stream ignored
// RECV  | accepting coefficient bytes
// WRITE | one-cycle c_WE pulse for the current address
// CSUM  | accepting the trailing checksum byte
// DONE  | full coefficient set resident
// ERR   | checksum mismatch
module fir_coeff_loader #(
    parameter int  ORD   = fir_pkg::ORD,
    parameter int  C     = fir_pkg::C,
    localparam int NCOEF = (ORD + 1) / 2,
    localparam int AW    = $clog2(NCOEF),
    localparam int BPC   = C / 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [7:0]    s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic          c_WE,
    output logic [AW-1:0] c_addr,
    output logic [C-1:0]  c_in,
    output logic          busy,
    output logic          done,
    output logic          err
);
    import fir_pkg::*;

    loader_state_e state, state_nxt;
    logic [AW-1:0] addr, addr_nxt;
    logic [C-1:0]  word;
    logic          word_valid;
    logic          accept;
    logic          s_ready_nxt, c_we_nxt, busy_nxt, done_nxt;
    logic [AW-1:0] c_addr_nxt;
    logic [C-1:0]  c_in_nxt;

    assign accept = s_valid && s_ready && (state == RECV);

    fir_coeff_assembler #(.BPC(BPC)) u_asm (
        .clk        (clk),
        .rst        (rst),
        .clr        (start),
        .accept     (accept),
        .s_data     (s_data),
        .word_valid (word_valid),
        .word       (word)
    );

`ifdef FIR_COEFF_LOADER_CSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk) begin
        if (rst || start) begin
            csum <= '0;
        end else if (accept) begin
            csum <= csum ^ s_data;
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        case (state)
            RECV: if (word_valid) state_nxt = WRITE;
            WRITE: begin
                if (addr == AW'(NCOEF - 1)) begin
`ifdef FIR_COEFF_LOADER_CSUM_EN
                    state_nxt = CSUM;
`else
                    state_nxt = DONE;
`endif
                end else begin
                    addr_nxt  = addr + 1'b1;
                    state_nxt = RECV;
                end
            end
`ifdef FIR_COEFF_LOADER_CSUM_EN
            CSUM: if (s_valid && s_ready) state_nxt = (s_data == csum) ? DONE : ERR;
`endif
            default: ;
        endcase
        // A write already presented still completes; the new load starts from address 0.
        if (start) begin
            state_nxt = RECV;
            addr_nxt  = '0;
        end
        s_ready_nxt = (state_nxt == RECV) || (state_nxt == CSUM);
        c_we_nxt    = (state_nxt == WRITE);
        busy_nxt    = s_ready_nxt || c_we_nxt;
        done_nxt    = (state_nxt == DONE);
        c_addr_nxt  = c_we_nxt ? addr : c_addr;
        c_in_nxt    = c_we_nxt ? word : c_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            addr    <= '0;
            s_ready <= 1'b0;
            c_WE    <= 1'b0;
            c_addr  <= '0;
            c_in    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            addr    <= addr_nxt;
            s_ready <= s_ready_nxt;
            c_WE    <= c_we_nxt;
            c_addr  <= c_addr_nxt;
            c_in    <= c_in_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
        end
    end

`ifdef FIR_COEFF_LOADER_CSUM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else begin
            err <= (state_nxt == ERR);
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Scoreboard bench for fir_coeff_loader: expected writes queued as bytes are driven, popped on c_WE.
module tb_fir_coeff_loader;
    import fir_pkg::*;

`ifdef FIR_COEFF_LOADER_CSUM_EN
    localparam int DONE_CYC = 386;
    localparam int NB       = 2 * NCOEF + 1;
`else
    localparam int DONE_CYC = 385;
    localparam int NB       = 2 * NCOEF;
`endif

    logic          clk = 1'b0;
    logic          rst, start, s_valid;
    logic [7:0]    s_data;
    logic          s_ready, c_WE, busy, done, err;
    logic [AW-1:0] c_addr;
    logic [C-1:0]  c_in;

    int checks = 0;
    int passes = 0;
    logic [AW+C-1:0] exp_q[$];
    logic [AW+C-1:0] mon_exp;
    logic [7:0]      bytes_arr [0:2*NCOEF];
    bit              send_to;

    always #5 clk = ~clk;

    fir_coeff_loader #(.ORD(ORD), .C(C)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .c_WE    (c_WE),
        .c_addr  (c_addr),
        .c_in    (c_in),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always @(negedge clk) begin
        if (c_WE === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_write: c_addr=%0d c_in=%h, no write expected", c_addr, c_in);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({c_addr, c_in} !== mon_exp)
                    $display("FAIL write: got addr=%0d data=%h, expected addr=%0d data=%h",
                             c_addr, c_in, mon_exp[AW+C-1:C], mon_exp[C-1:0]);
                else
                    passes++;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", passes, checks + 1);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_bytes();
        for (int k = 0; k < NCOEF; k++) begin
            bytes_arr[2*k]   = 8'h00;
            bytes_arr[2*k+1] = 8'(k + 1);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit throttle);
        bit rdy;
        int guard;
        if (send_to) return;
        if (throttle) begin
            s_valid = 1'b0;
            step();
        end
        s_data  = b;
        s_valid = 1'b1;
        guard   = 0;
        do begin
            rdy = s_ready;
            step();
            guard++;
        end while (!rdy && guard < 50);
        s_valid = 1'b0;
        if (!rdy) send_to = 1'b1;
    endtask

    // Pulses start, streams bytes_arr (plus checksum in that build) and reports what it observed.
    task automatic run_load(input bit throttle, input bit corrupt, output int n_done,
                            output bit timed_out, output bit first_ok, output bit spacing_ok);
        logic [7:0] x;
        int         last_we;
        int         n;
        x = 8'h00;
        for (int i = 0; i < 2 * NCOEF; i++) x ^= bytes_arr[i];
        bytes_arr[2*NCOEF] = corrupt ? (x ^ 8'h01) : x;
        for (int k = 0; k < NCOEF; k++)
            exp_q.push_back({AW'(k), bytes_arr[2*k], bytes_arr[2*k+1]});
        send_to = 1'b0; first_ok = 1'b0; spacing_ok = 1'b1; timed_out = 1'b1;
        n_done = 0; last_we = 0; n = 0;
        start = 1'b1;
        fork
            begin
                step();
                for (int i = 0; i < NB; i++) send_byte(bytes_arr[i], throttle);
            end
            begin
                for (int i = 0; i < 4000; i++) begin
                    step();
                    n++;
                    if (n == 1) begin
                        start    = 1'b0;
                        first_ok = (s_ready === 1'b1) && (busy === 1'b1);
                    end
                    if (c_WE === 1'b1) begin
                        if (n - last_we != 3) spacing_ok = 1'b0;
                        last_we = n;
                    end
                    if (done === 1'b1 || err === 1'b1) begin
                        timed_out = 1'b0;
                        n_done    = n;
                        break;
                    end
                end
            end
        join
        if (send_to) timed_out = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
        repeat (3) step();
        checks++; if (s_ready !== 1'b0) $display("FAIL reset_s_ready: got %b expected 0", s_ready); else passes++;
        checks++; if (c_WE !== 1'b0) $display("FAIL reset_c_WE: got %b expected 0", c_WE); else passes++;
        checks++; if (c_addr !== '0) $display("FAIL reset_c_addr: got %0d expected 0", c_addr); else passes++;
        checks++; if (c_in !== '0) $display("FAIL reset_c_in: got %h expected 0", c_in); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passes++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else passes++;
        checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b expected 0", err); else passes++;
        rst = 1'b0;
        step();
    endtask

    task automatic test_idle_ignore();
        int  n_done;
        bit  to, f_ok, sp_ok;
        s_data = 8'hAA; s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (s_ready !== 1'b0) $display("FAIL idle_s_ready: got %b expected 0", s_ready); else passes++;
            checks++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b expected 0", busy); else passes++;
        end
        fill_bytes();
        bytes_arr[0] = 8'hAA;
        run_load(1'b0, 1'b0, n_done, to, f_ok, sp_ok);
        checks++; if (to) $display("FAIL idle_load_timeout: load did not complete"); else passes++;
        checks++; if (exp_q.size() != 0) $display("FAIL idle_writes_left: %0d outstanding, expected 0", exp_q.size()); else passes++;
        checks++; if (done !== 1'b1) $display("FAIL idle_done: got %b expected 1", done); else passes++;
    endtask

    task automatic test_nominal();
        int  n_done;
        bit  to, f_ok, sp_ok;
        fill_bytes();
        run_load(1'b0, 1'b0, n_done, to, f_ok, sp_ok);
        checks++; if (to) $display("FAIL nominal_timeout: load did not complete"); else passes++;
        checks++; if (!f_ok) $display("FAIL nominal_start_latency: s_ready/busy not 1 the cycle after start"); else passes++;
        checks++; if (!sp_ok) $display("FAIL nominal_we_spacing: c_WE pulses not 3 cycles apart"); else passes++;
        checks++; if (n_done != DONE_CYC) $display("FAIL nominal_done_cycle: got %0d expected %0d", n_done, DONE_CYC); else passes++;
        checks++; if (exp_q.size() != 0) $display("FAIL nominal_writes_left: %0d outstanding, expected 0", exp_q.size()); else passes++;
        checks++; if (busy !== 1'b0 || err !== 1'b0) $display("FAIL nominal_status: busy=%b err=%b expected 0 0", busy, err); else passes++;
    endtask

    task automatic test_throttled();
        int  n_done;
        bit  to, f_ok, sp_ok;
        fill_bytes();
        run_load(1'b1, 1'b0, n_done, to, f_ok, sp_ok);
        checks++; if (to) $display("FAIL throttled_timeout: load did not complete"); else passes++;
        checks++; if (n_done <= DONE_CYC) $display("FAIL throttled_done_cycle: got %0d expected more than %0d", n_done, DONE_CYC); else passes++;
        checks++; if (exp_q.size() != 0) $display("FAIL throttled_writes_left: %0d outstanding, expected 0", exp_q.size()); else passes++;
        checks++; if (done !== 1'b1) $display("FAIL throttled_done: got %b expected 1", done); else passes++;
    endtask

    task automatic test_restart();
        int  n_done;
        bit  to, f_ok, sp_ok;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (done !== 1'b0) $display("FAIL restart_done_clear: got %b expected 0", done); else passes++;
        send_to = 1'b0;
        for (int k = 0; k < 10; k++) exp_q.push_back({AW'(k), 8'h00, 8'(k + 1)});
        for (int i = 0; i < 20; i++) send_byte((i % 2 == 1) ? 8'(i / 2 + 1) : 8'h00, 1'b0);
        send_byte(8'h55, 1'b0);
        checks++; if (send_to) $display("FAIL restart_prefix_timeout: bytes not accepted"); else passes++;
        checks++; if (exp_q.size() != 0) $display("FAIL restart_prefix_writes: %0d outstanding, expected 0", exp_q.size()); else passes++;
        fill_bytes();
        run_load(1'b0, 1'b0, n_done, to, f_ok, sp_ok);
        checks++; if (to) $display("FAIL restart_timeout: load did not complete"); else passes++;
        checks++; if (n_done != DONE_CYC) $display("FAIL restart_done_cycle: got %0d expected %0d", n_done, DONE_CYC); else passes++;
        checks++; if (exp_q.size() != 0) $display("FAIL restart_writes_left: %0d outstanding, expected 0", exp_q.size()); else passes++;
    endtask

    task automatic test_reset_midload();
        start = 1'b1;
        step();
        start = 1'b0;
        send_to = 1'b0;
        for (int k = 0; k < 50; k++) exp_q.push_back({AW'(k), 8'h00, 8'(k + 1)});
        for (int i = 0; i < 100; i++) send_byte((i % 2 == 1) ? 8'(i / 2 + 1) : 8'h00, 1'b0);
        send_byte(8'h77, 1'b0);
        checks++; if (send_to) $display("FAIL midrst_prefix_timeout: bytes not accepted"); else passes++;
        checks++; if (exp_q.size() != 0) $display("FAIL midrst_prefix_writes: %0d outstanding, expected 0", exp_q.size()); else passes++;
        checks++; if (busy !== 1'b1) $display("FAIL midrst_busy_before: got %b expected 1", busy); else passes++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if ({s_ready, c_WE, busy, done, err} !== 5'b0)
            $display("FAIL midrst_flags: s_ready=%b c_WE=%b busy=%b done=%b err=%b expected all 0", s_ready, c_WE, busy, done, err);
        else passes++;
        checks++; if (c_addr !== '0 || c_in !== '0) $display("FAIL midrst_bus: c_addr=%0d c_in=%h expected 0 0", c_addr, c_in); else passes++;
        s_data = 8'h33; s_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++; if (s_ready !== 1'b0 || busy !== 1'b0)
                $display("FAIL midrst_idle: s_ready=%b busy=%b expected 0 0", s_ready, busy);
            else passes++;
        end
        s_valid = 1'b0;
        step();
    endtask

`ifdef FIR_COEFF_LOADER_CSUM_EN
    task automatic test_checksum();
        int  n_done;
        bit  to, f_ok, sp_ok;
        fill_bytes();
        run_load(1'b0, 1'b0, n_done, to, f_ok, sp_ok);
        checks++; if (to) $display("FAIL csum_good_timeout: load did not complete"); else passes++;
        checks++; if (done !== 1'b1 || err !== 1'b0) $display("FAIL csum_good: done=%b err=%b expected 1 0", done, err); else passes++;
        fill_bytes();
        run_load(1'b0, 1'b1, n_done, to, f_ok, sp_ok);
        checks++; if (to) $display("FAIL csum_bad_timeout: load did not complete"); else passes++;
        checks++; if (done !== 1'b0 || err !== 1'b1) $display("FAIL csum_bad: done=%b err=%b expected 0 1", done, err); else passes++;
        checks++; if (n_done != DONE_CYC) $display("FAIL csum_bad_cycle: got %0d expected %0d", n_done, DONE_CYC); else passes++;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (err !== 1'b0 || busy !== 1'b1) $display("FAIL csum_err_clear: err=%b busy=%b expected 0 1", err, busy); else passes++;
    endtask
`endif

    initial begin
        test_reset();
        test_idle_ignore();
        test_nominal();
        test_throttled();
        test_restart();
        test_reset_midload();
`ifdef FIR_COEFF_LOADER_CSUM_EN
        test_checksum();
`endif
        repeat (2) step();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
